// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave sequencing logic.
package spi_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        WAIT_TX,
        SEND,
        DONE
    } state_e;

    // Command codes carried in rx_data[9:8]; forwarded to the RAM untouched
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Default geometry
    localparam int RX_W_DEF       = 10;
    localparam int TX_W_DEF       = 8;
    localparam int TX_TIMEOUT_DEF = 16;

    // Width of a down-counter able to hold the largest of three reload values
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Loadable down-counter with terminal-count flag; shared by the rx bit count,
// the WAIT_TX timeout and the SEND shift count.
module spi_bit_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count;

    // Load has priority over decrement; decrement saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave sequencer: frames transactions on ss_n, deserialises MOSI into an
// rx word for the RAM, and drives the PISO serialiser for read-data frames.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int RX_W       = RX_W_DEF,
    parameter int TX_W       = TX_W_DEF,
    parameter int TX_TIMEOUT = TX_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ss_n,
    input  logic            mosi,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic            tx_valid,
    output logic            piso_load,
    output logic            piso_shift,
    output logic            miso_oe,
    output logic            tx_err,
    output logic            busy
);

    localparam int CNT_W = cnt_width(RX_W, TX_W, TX_TIMEOUT);

    // Reload values: the counter runs down to zero, so N cycles load N-1
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_W - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TX_TIMEOUT - 1);

    state_e            state;
    state_e            state_nxt;
    logic              rd_addr_done;
    logic [RX_W-1:0]   rx_shift;

    logic              abort;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_dec;
    logic              cnt_tc;
    logic              shift_en;
    logic              rx_fire;
    logic              rd_set;
    logic              rd_clr;

    spi_bit_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    // ss_n rising mid-transaction discards the frame
    assign abort = ss_n && (state != IDLE) && (state != DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter control and strobe outputs
    always_comb begin
        state_nxt  = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        shift_en   = 1'b0;
        rx_fire    = 1'b0;
        rd_set     = 1'b0;
        rd_clr     = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        tx_err     = 1'b0;

        if (abort) begin
            // Counter reload to zero clears any bit count / timeout in flight
            state_nxt = IDLE;
            cnt_load  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!ss_n) state_nxt = CHK_CMD;
                end
                CHK_CMD: begin
                    cnt_load = 1'b1;
                    cnt_val  = RX_LAST;
                    if (!mosi)             state_nxt = WRITE;
                    else if (rd_addr_done) state_nxt = READ_DATA;
                    else                   state_nxt = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    shift_en = 1'b1;
                    if (cnt_tc) begin
                        rx_fire = 1'b1;
                        if (state == READ_DATA) begin
                            cnt_load  = 1'b1;
                            cnt_val   = TO_LAST;
                            state_nxt = WAIT_TX;
                        end else begin
                            rd_set    = (state == READ_ADD);
                            state_nxt = DONE;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                WAIT_TX: begin
                    // tx_valid on the final timeout cycle still wins
                    if (tx_valid) begin
                        piso_load = 1'b1;
                        cnt_load  = 1'b1;
                        cnt_val   = TX_LAST;
                        state_nxt = SEND;
                    end else if (cnt_tc) begin
                        tx_err    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                SEND: begin
                    piso_shift = 1'b1;
                    if (cnt_tc) begin
                        rd_clr    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                DONE: begin
                    if (ss_n) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign miso_oe = piso_shift;
    assign busy    = (state != IDLE);

    // MOSI deserialiser and rx word handoff; rx_valid trails the last bit by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= rx_fire;
            if (shift_en) rx_shift <= {rx_shift[RX_W-2:0], mosi};
            if (rx_fire)  rx_data  <= {rx_shift[RX_W-2:0], mosi};
        end
    end

    // Read-address/read-data ordering: set by a completed address frame,
    // cleared once read data has been fully shifted out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_done <= 1'b0;
        end else if (rd_set) begin
            rd_addr_done <= 1'b1;
        end else if (rd_clr) begin
            rd_addr_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: directed scenarios plus randomized frames checked
// against a transaction-level model of the read-address/read-data ordering.
module tb_spi_slave_ctrl;

    localparam int RX_W       = 10;
    localparam int TX_W       = 8;
    localparam int TX_TIMEOUT = 16;
    localparam int WAIT_CYC   = 40;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            ss_n     = 1'b1;
    logic            mosi     = 1'b0;
    logic            tx_valid = 1'b0;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic            piso_load;
    logic            piso_shift;
    logic            miso_oe;
    logic            tx_err;
    logic            busy;

    int errors = 0;
    int checks = 0;

    // Model: has a read-address frame completed without a finished read since?
    bit model_rd = 1'b0;

    // Observations from the frame driver
    int              f_vcnt;
    int              f_vpos;
    logic [RX_W-1:0] f_vdata;
    logic            f_busy_end;
    // Observations from the post-frame phase
    int w_nload, w_load_at, w_nerr, w_err_at, w_nshift, w_first, w_last;
    int w_oe_mis, w_nvld, w_idle;
    logic e_busy;

    always #5 clk = ~clk;

    spi_slave_ctrl #(
        .RX_W       (RX_W),
        .TX_W       (TX_W),
        .TX_TIMEOUT (TX_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_valid   (tx_valid),
        .piso_load  (piso_load),
        .piso_shift (piso_shift),
        .miso_oe    (miso_oe),
        .tx_err     (tx_err),
        .busy       (busy)
    );

    // Inputs change and outputs are sampled on the falling edge.
    // Drives the command bit then nbits word bits; abort raises ss_n on the next bit.
    task automatic drive_frame(input logic cmd, input logic [RX_W-1:0] word,
                               input int nbits, input bit abort);
        f_vcnt = 0; f_vpos = -1; f_vdata = '0; f_busy_end = 1'b1;
        ss_n = 1'b0;
        @(negedge clk);
        mosi = cmd;
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = word[RX_W-1-i];
            @(negedge clk);
            if (rx_valid) begin f_vcnt++; f_vpos = i; f_vdata = rx_data; end
        end
        if (abort) begin
            ss_n = 1'b1;
            if (nbits < RX_W) mosi = word[RX_W-1-nbits];
            @(negedge clk);
            if (rx_valid) f_vcnt++;
            f_busy_end = busy;
            @(negedge clk);
            if (rx_valid) f_vcnt++;
        end
    endtask

    // Holds ss_n low with random MOSI, pulsing tx_valid in cycle txv_at (0 = never)
    task automatic wait_phase(input int txv_at);
        w_nload = 0; w_load_at = -1; w_nerr = 0; w_err_at = -1;
        w_nshift = 0; w_first = -1; w_last = -1; w_oe_mis = 0; w_nvld = 0; w_idle = 0;
        for (int c = 1; c <= WAIT_CYC; c++) begin
            tx_valid = (c == txv_at);
            mosi     = 1'($urandom);
            #1;
            if (piso_load) begin w_nload++; w_load_at = c; end
            if (tx_err) begin w_nerr++; w_err_at = c; end
            if (piso_shift) begin
                w_nshift++;
                if (w_first < 0) w_first = c;
                w_last = c;
            end
            if (miso_oe !== piso_shift) w_oe_mis++;
            if (c > 1 && rx_valid) w_nvld++;
            if (!busy) w_idle++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        @(negedge clk);
        e_busy = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ss_n = 1'b0; mosi = 1'b1; tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_rx_data: got %h want 000", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (piso_load !== 1'b0) begin errors++; $display("FAIL reset_piso_load: got %b want 0", piso_load); end
        checks++; if (piso_shift !== 1'b0) begin errors++; $display("FAIL reset_piso_shift: got %b want 0", piso_shift); end
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
        checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_tx_err: got %b want 0", tx_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0;
        rst_n = 1'b1;
        model_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        drive_frame(1'b0, 10'h05A, RX_W, 1'b0);
        checks++; if (f_vcnt !== 1) begin errors++; $display("FAIL write_vld_count: got %0d want 1", f_vcnt); end
        checks++; if (f_vpos !== RX_W-1) begin errors++; $display("FAIL write_vld_pos: got %0d want %0d", f_vpos, RX_W-1); end
        checks++; if (f_vdata !== 10'h05A) begin errors++; $display("FAIL write_data: got %h want 05a", f_vdata); end
        wait_phase(2);
        checks++; if (w_nvld !== 0) begin errors++; $display("FAIL write_extra_vld: got %0d want 0", w_nvld); end
        checks++; if (w_idle !== 0) begin errors++; $display("FAIL write_busy_hold: idle cycles %0d want 0", w_idle); end
        checks++; if (w_nload !== 0) begin errors++; $display("FAIL write_txv_ignored: loads %0d want 0", w_nload); end
        end_frame();
        checks++; if (e_busy !== 1'b0) begin errors++; $display("FAIL write_busy_end: got %b want 0", e_busy); end
    endtask

    task automatic test_read_seq();
        drive_frame(1'b1, 10'h230, RX_W, 1'b0);
        checks++; if (f_vdata !== 10'h230 || f_vcnt !== 1) begin errors++; $display("FAIL rdaddr_data: got %h x%0d want 230 x1", f_vdata, f_vcnt); end
        wait_phase(0);
        checks++; if (w_nerr !== 0) begin errors++; $display("FAIL rdaddr_no_wait: tx_err %0d want 0", w_nerr); end
        end_frame();
        model_rd = 1'b1;
        drive_frame(1'b1, 10'h300, RX_W, 1'b0);
        checks++; if (f_vdata !== 10'h300) begin errors++; $display("FAIL rddata_data: got %h want 300", f_vdata); end
        wait_phase(3);
        checks++; if (w_nload !== 1 || w_load_at !== 3) begin errors++; $display("FAIL rddata_load: got %0d at %0d want 1 at 3", w_nload, w_load_at); end
        checks++; if (w_nshift !== TX_W) begin errors++; $display("FAIL rddata_shift_len: got %0d want %0d", w_nshift, TX_W); end
        checks++; if (w_first !== 4 || w_last !== 3 + TX_W) begin errors++; $display("FAIL rddata_shift_win: got %0d..%0d want 4..%0d", w_first, w_last, 3 + TX_W); end
        checks++; if (w_oe_mis !== 0) begin errors++; $display("FAIL rddata_oe: mismatched cycles %0d want 0", w_oe_mis); end
        end_frame();
        model_rd = 1'b0;
        // Cleared ordering flag: the next read frame must be an address frame
        drive_frame(1'b1, 10'($urandom), RX_W, 1'b0);
        wait_phase(5);
        checks++; if (w_nload !== 0 || w_nerr !== 0) begin errors++; $display("FAIL rd_flag_cleared: load %0d err %0d want 0 0", w_nload, w_nerr); end
        end_frame();
        model_rd = 1'b1;
    endtask

    task automatic test_timeout();
        drive_frame(1'b1, 10'h3C3, RX_W, 1'b0);
        wait_phase(0);
        checks++; if (w_nerr !== 1 || w_err_at !== TX_TIMEOUT) begin errors++; $display("FAIL timeout_err: got %0d at %0d want 1 at %0d", w_nerr, w_err_at, TX_TIMEOUT); end
        checks++; if (w_nload !== 0 || w_nshift !== 0) begin errors++; $display("FAIL timeout_no_tx: load %0d shift %0d want 0 0", w_nload, w_nshift); end
        end_frame();
        // Flag kept after timeout: next read frame is read-data again
        drive_frame(1'b1, 10'h3FF, RX_W, 1'b0);
        wait_phase(TX_TIMEOUT);
        checks++; if (w_nload !== 1 || w_nerr !== 0) begin errors++; $display("FAIL timeout_flag_kept: load %0d err %0d want 1 0", w_nload, w_nerr); end
        end_frame();
        model_rd = 1'b0;
    endtask

    task automatic test_abort();
        drive_frame(1'b0, 10'h2AA, 6, 1'b1);
        checks++; if (f_vcnt !== 0) begin errors++; $display("FAIL abort_no_vld: got %0d want 0", f_vcnt); end
        checks++; if (f_busy_end !== 1'b0) begin errors++; $display("FAIL abort_idle: busy %b want 0", f_busy_end); end
        drive_frame(1'b0, 10'h155, RX_W-1, 1'b1);
        checks++; if (f_vcnt !== 0) begin errors++; $display("FAIL abort_last_bit: got %0d want 0", f_vcnt); end
        drive_frame(1'b0, 10'h1FF, RX_W, 1'b0);
        checks++; if (f_vdata !== 10'h1FF || f_vcnt !== 1) begin errors++; $display("FAIL abort_next_write: got %h x%0d want 1ff x1", f_vdata, f_vcnt); end
        wait_phase(0);
        end_frame();
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic            cmd;
            logic [RX_W-1:0] word;
            bit              ab;
            int              nb, txv;
            int              x_nload, x_nerr, x_nshift, x_first;
            cmd  = 1'($urandom);
            word = RX_W'($urandom);
            ab   = ($urandom_range(0, 4) == 0);
            nb   = ab ? $urandom_range(0, RX_W-1) : RX_W;
            txv  = $urandom_range(0, TX_TIMEOUT + 2);
            drive_frame(cmd, word, nb, ab);
            if (ab) begin
                checks++; if (f_vcnt !== 0 || f_busy_end !== 1'b0) begin errors++; $display("FAIL rnd_abort[%0d]: vld %0d busy %b want 0 0", n, f_vcnt, f_busy_end); end
            end else begin
                checks++; if (f_vcnt !== 1 || f_vdata !== word) begin errors++; $display("FAIL rnd_rx[%0d]: got %h x%0d want %h x1", n, f_vdata, f_vcnt, word); end
                x_nload = 0; x_nerr = 0; x_nshift = 0; x_first = -1;
                if (cmd && model_rd) begin
                    if (txv >= 1 && txv <= TX_TIMEOUT) begin
                        x_nload = 1; x_nshift = TX_W; x_first = txv + 1;
                        model_rd = 1'b0;
                    end else begin
                        x_nerr = 1;
                    end
                end else if (cmd) begin
                    model_rd = 1'b1;
                end
                wait_phase(txv);
                checks++; if (w_nload !== x_nload || w_nerr !== x_nerr || w_nshift !== x_nshift) begin
                    errors++; $display("FAIL rnd_tx[%0d]: load/err/shift %0d/%0d/%0d want %0d/%0d/%0d", n, w_nload, w_nerr, w_nshift, x_nload, x_nerr, x_nshift);
                end
                if (x_nload == 1) begin
                    checks++; if (w_load_at !== txv || w_first !== x_first) begin errors++; $display("FAIL rnd_tx_time[%0d]: load %0d shift %0d want %0d %0d", n, w_load_at, w_first, txv, x_first); end
                end
                if (x_nerr == 1) begin
                    checks++; if (w_err_at !== TX_TIMEOUT) begin errors++; $display("FAIL rnd_timeout[%0d]: got %0d want %0d", n, w_err_at, TX_TIMEOUT); end
                end
                checks++; if (w_oe_mis !== 0 || w_nvld !== 0 || w_idle !== 0) begin errors++; $display("FAIL rnd_misc[%0d]: oe %0d vld %0d idle %0d want 0 0 0", n, w_oe_mis, w_nvld, w_idle); end
                end_frame();
            end
        end
    endtask

    task automatic test_reset_in_send();
        if (!model_rd) begin
            drive_frame(1'b1, 10'h2C0, RX_W, 1'b0);
            wait_phase(0);
            end_frame();
            model_rd = 1'b1;
        end
        drive_frame(1'b1, 10'h3A5, RX_W, 1'b0);
        tx_valid = 1'b1;
        #1;
        checks++; if (piso_load !== 1'b1) begin errors++; $display("FAIL rst_send_load: got %b want 1", piso_load); end
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (piso_shift !== 1'b1) begin errors++; $display("FAIL rst_send_pre: shift %b want 1", piso_shift); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (piso_shift !== 1'b0 || miso_oe !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_send_drop: shift %b oe %b busy %b want 0 0 0", piso_shift, miso_oe, busy);
        end
        model_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ss_n = 1'b1;
        @(negedge clk);
        drive_frame(1'b1, 10'h2F0, RX_W, 1'b0);
        checks++; if (f_vdata !== 10'h2F0) begin errors++; $display("FAIL rst_post_data: got %h want 2f0", f_vdata); end
        wait_phase(3);
        checks++; if (w_nload !== 0 || w_nerr !== 0) begin errors++; $display("FAIL rst_post_readadd: load %0d err %0d want 0 0", w_nload, w_nerr); end
        end_frame();
        model_rd = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_seq();
        test_timeout();
        test_abort();
        test_random();
        test_reset_in_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
